// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
// Covers the descriptor layout, kind codes, FSM states and the one-hot decode helpers.
package cgra_cfg_pkg;
  localparam int INST_W = 48;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int HOLD_W = 8;
  localparam int DESC_W = 3 + 2 + 2 + HOLD_W + INST_W;

  // descriptor = {kind, row, col, hold, payload}, kind at MSB
  localparam int PAY_LSB  = 0;
  localparam int HOLD_LSB = INST_W;
  localparam int COL_LSB  = HOLD_LSB + HOLD_W;
  localparam int ROW_LSB  = COL_LSB + 2;
  localparam int KIND_LSB = ROW_LSB + 2;

  typedef enum logic [2:0] {
    K_PE  = 3'd0,
    K_LSU = 3'd1,
    K_SPM = 3'd2,
    K_RUN = 3'd3,
    K_END = 3'd4
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRIVE,
    S_DONE,
    S_ERR
  } state_e;

  // index 0 maps to the MSB of the select vector
  function automatic logic [ROWS-1:0] row_onehot(input logic [1:0] idx);
    return {1'b1, {(ROWS-1){1'b0}}} >> idx;
  endfunction

  function automatic logic [COLS-1:0] col_onehot(input logic [1:0] idx);
    return {1'b1, {(COLS-1){1'b0}}} >> idx;
  endfunction
endpackage

// File: rtl/cgra_cfg_hold_timer.sv
// Loadable down-counter used to time how long a descriptor is driven.
// Stops at zero rather than wrapping, so the maximum hold value is safe.
module cgra_cfg_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] hold,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (load)         cnt <= hold;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Turns a stream of configuration descriptors into timed, one-hot host-controller strobes.
// The FSM and every output register live here; the hold count sits in cgra_cfg_hold_timer.
module cgra_cfg_sequencer
  import cgra_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [DESC_W-1:0] desc_data,
  output logic [ROWS-1:0]   init_row,
  output logic [COLS-1:0]   init_pe,
  output logic              init_lsu,
  output logic              init_spm,
  output logic [INST_W-1:0] inst,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e state, nxt;
  kind_e  d_kind;
  logic   hs, ld, zero;
  logic [1:0]        d_row, d_col;
  logic [HOLD_W-1:0] d_hold;
  logic [INST_W-1:0] d_pay;

  assign d_kind = kind_e'(desc_data[KIND_LSB +: 3]);
  assign d_row  = desc_data[ROW_LSB +: 2];
  assign d_col  = desc_data[COL_LSB +: 2];
  assign d_hold = desc_data[HOLD_LSB +: HOLD_W];
  assign d_pay  = desc_data[PAY_LSB +: INST_W];

  // an aborted handshake must not consume the descriptor
  assign desc_ready = (state == S_FETCH) && !abort;
  assign hs         = desc_valid && desc_ready;
  assign busy       = (state == S_FETCH) || (state == S_DRIVE);

  cgra_cfg_hold_timer #(.W(HOLD_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .load (ld),
    .hold (d_hold),
    .zero (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    ld  = 1'b0;
    case (state)
      S_IDLE:  if (start) nxt = S_FETCH;
      S_FETCH: if (hs) begin
        case (d_kind)
          K_PE, K_LSU, K_SPM, K_RUN: begin
            nxt = S_DRIVE;
            ld  = 1'b1;
          end
          K_END:   nxt = S_DONE;
          default: nxt = S_ERR;
        endcase
      end
      S_DRIVE: if (zero) nxt = S_FETCH;
      S_DONE, S_ERR: if (start) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_row <= '0;
      init_pe  <= '0;
      init_lsu <= 1'b0;
      init_spm <= 1'b0;
      inst     <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= (nxt == S_DONE);
      err  <= (nxt == S_ERR);
      if (abort || (state == S_DRIVE && zero)) begin
        init_row <= '0;
        init_pe  <= '0;
        init_lsu <= 1'b0;
        init_spm <= 1'b0;
        inst     <= '0;
        run      <= 1'b0;
      end else if (ld) begin
        init_row <= (d_kind == K_PE || d_kind == K_LSU) ? row_onehot(d_row) : '0;
        init_pe  <= (d_kind == K_PE) ? col_onehot(d_col) : '0;
        init_lsu <= (d_kind == K_LSU);
        init_spm <= (d_kind == K_SPM);
        inst     <= (d_kind == K_RUN) ? '0 : d_pay;
        run      <= (d_kind == K_RUN);
      end else if (state == S_DRIVE) begin
        run <= 1'b0;  // run is a single-cycle pulse even for long holds
      end
    end
  end
endmodule
